// File: rtl/riscv_pkg.sv
// Shared encodings for the load/store unit: funct3 access codes, FSM states and fault causes.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUS  = 2'b01,
      ST_DONE = 2'b10
   } lsu_state_t;

   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-bus side of the load/store unit: single-cycle req/ack handshake with byte enables.
interface load_store_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and replicated store data on the way out,
// lane select plus sign/zero extension for load data on the way back.
module lsu_align
   import riscv_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        ld_signed;

   // Access size comes from funct3[1:0]; the unsigned bit only matters for loads.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = st_data;
      case (st_funct3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         2'b01: begin
            st_be    = st_off[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte   = ld_word[8*ld_off +: 8];
      ld_half   = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
      ld_signed = ~ld_funct3[2];
      case (ld_funct3[1:0])
         2'b00:   ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
         2'b01:   ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
         default: ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one load or store per start over a req/ack bus, one-cycle done pulse.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int ACK_TIMEOUT = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               we,
   input  logic [2:0]         funct3,
   input  logic [XLEN-1:0]    addr,
   input  logic [XLEN-1:0]    wdata,
   output logic               busy,
   output logic               done,
   output logic [XLEN-1:0]    rdata,
   output logic               fault,
   output logic [1:0]         fault_cause,
   load_store_unit_if.master  bus
);

   localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   lsu_state_t  state, state_next;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [2:0]  f3_q;
   logic [3:0]  be_q;
   logic        we_q, fault_q;
   logic [1:0]  cause_q;
   logic [CW-1:0] tcount;

   logic [3:0]  st_be;
   logic [31:0] st_wdata, ld_data;
   logic        misaligned, timed_out;
   logic        go_bus, go_fault, capture;
   logic [1:0]  fault_code;

   lsu_align u_align (
      .st_funct3 (funct3),
      .st_off    (addr[1:0]),
      .st_data   (wdata),
      .st_be     (st_be),
      .st_wdata  (st_wdata),
      .ld_funct3 (f3_q),
      .ld_off    (addr_q[1:0]),
      .ld_word   (bus.mem_rdata),
      .ld_data   (ld_data)
   );

`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   assign timed_out = (ACK_TIMEOUT > 0) && (tcount == CW'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Faulting requests skip the bus and go straight to DONE.
   always_comb begin
      state_next = state;
      go_bus     = 1'b0;
      go_fault   = 1'b0;
      capture    = 1'b0;
      fault_code = CAUSE_NONE;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (!f3_legal(funct3)) begin
                  state_next = ST_DONE;
                  go_fault   = 1'b1;
                  fault_code = CAUSE_ILLEGAL;
               end else if (misaligned) begin
                  state_next = ST_DONE;
                  go_fault   = 1'b1;
                  fault_code = CAUSE_MISALIGN;
               end else begin
                  state_next = ST_BUS;
                  go_bus     = 1'b1;
               end
            end
         end
         ST_BUS: begin
            if (bus.mem_ack) begin
               state_next = ST_DONE;
               capture    = 1'b1;
            end else if (timed_out) begin
               state_next = ST_DONE;
               go_fault   = 1'b1;
               fault_code = CAUSE_TIMEOUT;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         f3_q    <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         fault_q <= 1'b0;
         cause_q <= CAUSE_NONE;
         tcount  <= '0;
      end else begin
         if (go_bus) begin
            addr_q  <= addr;
            wdata_q <= st_wdata;
            f3_q    <= funct3;
            be_q    <= st_be;
            we_q    <= we;
            tcount  <= '0;
         end else if (state == ST_BUS) begin
            tcount  <= tcount + 1'b1;
         end
         if (capture && !we_q) rdata_q <= ld_data;
         if (capture || go_fault) begin
            fault_q <= go_fault;
            cause_q <= fault_code;
         end
      end
   end

   assign busy          = (state != ST_IDLE);
   assign done          = (state == ST_DONE);
   assign rdata         = rdata_q;
   assign fault         = fault_q;
   assign fault_cause   = cause_q;
   assign bus.mem_req   = (state == ST_BUS);
   assign bus.mem_we    = (state == ST_BUS) & we_q;
   assign bus.mem_be    = (state == ST_BUS) ? be_q : 4'b0000;
   assign bus.mem_addr  = {addr_q[31:2], 2'b00};
   assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (ACK_TIMEOUT=4); follows LSU_MISALIGN_TRAP_EN if defined.
module tb_load_store_unit;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, we;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        busy, done, fault;
   logic [31:0] rdata;
   logic [1:0]  fault_cause;

   int checks = 0;
   int passes = 0;

   logic [31:0] exp_rdata;

   logic        obs_req, obs_stable, obs_we, obs_fault;
   logic [3:0]  obs_be;
   logic [31:0] obs_addr, obs_wdata, obs_rdata;
   logic [1:0]  obs_cause;
   int          obs_done_cyc, obs_req_cycles;

   load_store_unit_if bus();

   load_store_unit #(.XLEN(32), .ACK_TIMEOUT(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .we          (we),
      .funct3      (funct3),
      .addr        (addr),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .rdata       (rdata),
      .fault       (fault),
      .fault_cause (fault_cause),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // Reference model: works in sizes, offsets and masks rather than in lane muxes.
   function automatic int m_size(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit m_legal(input logic [2:0] f3);
      return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5;
   endfunction

   function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
      return (a % m_size(f3)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
      int sz = m_size(f3);
      return int'(a % 4) / sz * sz;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      return 4'(((1 << m_size(f3)) - 1) << m_off(f3, a));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r = 0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % m_size(f3)) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
      longint unsigned mask = (64'd1 << (8 * m_size(f3))) - 1;
      longint unsigned v = (longint'(word) >> (8 * m_off(f3, a))) & mask;
      if (f3[2] == 1'b0 && m_size(f3) < 4 && v >= (mask + 1) / 2) v = v | ~mask;
      return v[31:0];
   endfunction

   task automatic run_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] word, input int delay);
      obs_req = 0; obs_stable = 1; obs_req_cycles = 0; obs_done_cyc = -1;
      obs_fault = 0; obs_cause = 0; obs_rdata = 0;
      start = 1; we = w; funct3 = f3; addr = a; wdata = wd;
      @(posedge clk); #1;
      start = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (bus.mem_req) begin
            if (!obs_req) begin
               obs_req = 1; obs_be = bus.mem_be; obs_addr = bus.mem_addr;
               obs_wdata = bus.mem_wdata; obs_we = bus.mem_we;
            end else if (obs_be !== bus.mem_be || obs_addr !== bus.mem_addr ||
                         obs_wdata !== bus.mem_wdata || obs_we !== bus.mem_we) begin
               obs_stable = 0;
            end
            if (obs_req_cycles == delay) begin
               bus.mem_ack = 1; bus.mem_rdata = word;
            end
            obs_req_cycles++;
         end
         if (done) begin
            obs_done_cyc = cyc; obs_rdata = rdata; obs_fault = fault; obs_cause = fault_cause;
         end
         @(posedge clk); #1;
         bus.mem_ack = 0; bus.mem_rdata = $urandom;
         if (obs_done_cyc >= 0) break;
      end
   endtask

   task automatic test_reset;
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passes++;
      checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done); else passes++;
      checks++; if (rdata !== 32'h0) $display("[TB] FAIL reset_rdata got %h want 0", rdata); else passes++;
      checks++; if (fault !== 1'b0 || fault_cause !== 2'b00)
         $display("[TB] FAIL reset_fault got %b/%b want 0/00", fault, fault_cause); else passes++;
      checks++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0)
         $display("[TB] FAIL reset_bus got req=%b we=%b be=%b want 0/0/0000", bus.mem_req, bus.mem_we, bus.mem_be);
      else passes++;
      reset = 0;
      exp_rdata = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_store_word;
      run_access(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 32'h0, 0);
      checks++; if (obs_be !== 4'b1111 || obs_we !== 1'b1 || obs_addr !== 32'h100)
         $display("[TB] FAIL sw_bus got be=%b we=%b addr=%h want 1111/1/00000100", obs_be, obs_we, obs_addr); else passes++;
      checks++; if (obs_wdata !== 32'hDEADBEEF) $display("[TB] FAIL sw_wdata got %h want deadbeef", obs_wdata); else passes++;
      checks++; if (obs_done_cyc !== 2 || obs_fault !== 1'b0)
         $display("[TB] FAIL sw_latency got cycle %0d fault %b want 2/0", obs_done_cyc, obs_fault); else passes++;
   endtask

   task automatic test_load_byte;
      run_access(1'b0, F3_B, 32'h103, 32'h0, 32'h80FF_0000, 0);
      checks++; if (obs_be !== 4'b1000) $display("[TB] FAIL lb_be got %b want 1000", obs_be); else passes++;
      checks++; if (obs_rdata !== 32'hFFFF_FF80) $display("[TB] FAIL lb_rdata got %h want ffffff80", obs_rdata); else passes++;
      run_access(1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF_0000, 1);
      checks++; if (obs_rdata !== 32'h0000_0080) $display("[TB] FAIL lbu_rdata got %h want 00000080", obs_rdata); else passes++;
      exp_rdata = 32'h80;
   endtask

   task automatic test_half;
      run_access(1'b1, F3_H, 32'h202, 32'h0000_1234, 32'h0, 0);
      checks++; if (obs_be !== 4'b1100 || obs_wdata !== 32'h1234_1234)
         $display("[TB] FAIL sh_bus got be=%b wdata=%h want 1100/12341234", obs_be, obs_wdata); else passes++;
      checks++; if (rdata !== exp_rdata) $display("[TB] FAIL sh_rdata_held got %h want %h", rdata, exp_rdata); else passes++;
      run_access(1'b0, F3_HU, 32'h202, 32'h0, 32'hABCD_0000, 0);
      checks++; if (obs_rdata !== 32'h0000_ABCD) $display("[TB] FAIL lhu_rdata got %h want 0000abcd", obs_rdata); else passes++;
      exp_rdata = 32'hABCD;
   endtask

   task automatic test_misalign;
      run_access(1'b0, F3_W, 32'h101, 32'h0, 32'h1357_9BDF, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      checks++; if (obs_req !== 1'b0 || obs_done_cyc !== 1 || obs_fault !== 1'b1 || obs_cause !== CAUSE_MISALIGN)
         $display("[TB] FAIL lw_misalign got req=%b cyc=%0d fault=%b cause=%b want 0/1/1/01",
                  obs_req, obs_done_cyc, obs_fault, obs_cause); else passes++;
`else
      checks++; if (obs_addr !== 32'h100 || obs_rdata !== 32'h1357_9BDF || obs_fault !== 1'b0)
         $display("[TB] FAIL lw_unaligned got addr=%h rdata=%h fault=%b want 00000100/13579bdf/0",
                  obs_addr, obs_rdata, obs_fault); else passes++;
      exp_rdata = 32'h1357_9BDF;
`endif
   endtask

   task automatic test_illegal;
      run_access(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 0);
      checks++; if (obs_req !== 1'b0 || obs_done_cyc !== 1 || obs_fault !== 1'b1 || obs_cause !== CAUSE_ILLEGAL)
         $display("[TB] FAIL illegal_f3 got req=%b cyc=%0d fault=%b cause=%b want 0/1/1/11",
                  obs_req, obs_done_cyc, obs_fault, obs_cause); else passes++;
   endtask

   task automatic test_timeout;
      run_access(1'b0, F3_W, 32'h80, 32'h0, 32'hFFFF_FFFF, 100);
      checks++; if (obs_req_cycles !== 4 || obs_done_cyc !== 5)
         $display("[TB] FAIL timeout_len got req_cycles=%0d done_cyc=%0d want 4/5", obs_req_cycles, obs_done_cyc); else passes++;
      checks++; if (obs_fault !== 1'b1 || obs_cause !== CAUSE_TIMEOUT || obs_rdata !== exp_rdata)
         $display("[TB] FAIL timeout_fault got fault=%b cause=%b rdata=%h want 1/10/%h",
                  obs_fault, obs_cause, obs_rdata, exp_rdata); else passes++;
   endtask

   task automatic test_reset_mid_bus;
      bit saw_done = 0;
      start = 1; we = 1; funct3 = F3_W; addr = 32'h300; wdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      start = 0;
      checks++; if (bus.mem_req !== 1'b1) $display("[TB] FAIL abort_req_up got %b want 1", bus.mem_req); else passes++;
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      checks++; if (bus.mem_req !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0)
         $display("[TB] FAIL abort_state got req=%b busy=%b rdata=%h want 0/0/0", bus.mem_req, busy, rdata); else passes++;
      exp_rdata = 0;
      bus.mem_ack = 1;
      repeat (5) begin
         if (done) saw_done = 1;
         @(posedge clk); #1;
      end
      bus.mem_ack = 0;
      checks++; if (saw_done !== 1'b0 || busy !== 1'b0)
         $display("[TB] FAIL abort_no_done got done_seen=%b busy=%b want 0/0", saw_done, busy); else passes++;
   endtask

   task automatic test_back_to_back;
      int nreq = 0, ndone = 0, nbus = 0;
      bit prev = 0;
      start = 1; we = 0; funct3 = F3_W; addr = 32'h40; wdata = 0;
      @(posedge clk); #1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         if (bus.mem_req && !prev) nreq++;
         prev = bus.mem_req;
         if (bus.mem_req) begin
            if (nbus == 2) begin bus.mem_ack = 1; bus.mem_rdata = 32'hC0FF_EE11; end
            nbus++;
         end
         if (done) begin ndone++; start = 0; end
         @(posedge clk); #1;
         bus.mem_ack = 0;
      end
      start = 0;
      checks++; if (nreq !== 1 || ndone !== 1)
         $display("[TB] FAIL start_while_busy got accesses=%0d dones=%0d want 1/1", nreq, ndone); else passes++;
      checks++; if (rdata !== 32'hC0FF_EE11) $display("[TB] FAIL busy_load_rdata got %h want c0ffee11", rdata); else passes++;
      exp_rdata = 32'hC0FF_EE11;
   endtask

   task automatic test_random;
      logic [2:0] codes [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      for (int n = 0; n < 40; n++) begin
         logic [2:0]  f3   = codes[$urandom_range(0, (n % 8 == 7) ? 7 : 4)];
         logic        w    = (f3[2] == 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0;
         logic [31:0] a    = $urandom;
         logic [31:0] wd   = $urandom;
         logic [31:0] word = $urandom;
         int          dly  = $urandom_range(0, 2);
         bit          bad  = !m_legal(f3) || m_misaligned(f3, a);
         run_access(w, f3, a, wd, word, dly);
         if (bad) begin
            checks++; if (obs_req !== 1'b0 || obs_done_cyc !== 1 || obs_fault !== 1'b1)
               $display("[TB] FAIL rnd%0d_fault got req=%b cyc=%0d fault=%b want 0/1/1", n, obs_req, obs_done_cyc, obs_fault);
            else passes++;
         end else begin
            checks++; if (obs_be !== m_be(f3, a) || obs_addr !== {a[31:2], 2'b00} || obs_we !== w || obs_stable !== 1'b1)
               $display("[TB] FAIL rnd%0d_bus got be=%b addr=%h we=%b stable=%b want %b/%h/%b/1",
                        n, obs_be, obs_addr, obs_we, obs_stable, m_be(f3, a), {a[31:2], 2'b00}, w);
            else passes++;
            if (w) begin
               checks++; if (obs_wdata !== m_wdata(f3, wd))
                  $display("[TB] FAIL rnd%0d_wdata got %h want %h", n, obs_wdata, m_wdata(f3, wd)); else passes++;
            end else begin
               exp_rdata = m_load(f3, a, word);
            end
            checks++; if (obs_done_cyc !== dly + 2 || obs_fault !== 1'b0 || obs_rdata !== exp_rdata)
               $display("[TB] FAIL rnd%0d_done got cyc=%0d fault=%b rdata=%h want %0d/0/%h",
                        n, obs_done_cyc, obs_fault, obs_rdata, dly + 2, exp_rdata);
            else passes++;
         end
      end
   endtask

   initial begin
      reset = 1; start = 0; we = 0; funct3 = 0; addr = 0; wdata = 0;
      bus.mem_ack = 0; bus.mem_rdata = 0;
      exp_rdata = 0;
      test_reset();
      test_store_word();
      test_load_byte();
      test_half();
      test_misalign();
      test_illegal();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid_bus();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
